clk_speed_switch_ctrl: RTL

- Sequences generation-speed changes (Gen2/Gen3/Gen4) for the local clock divider so downstream blocks never see runt or glitched clocks.
- On a speed request: waits for the link datapath to go idle, gates downstream clock enables, holds the divider in reset, applies the new gen_speed, waits for the divided clocks to settle, then releases.
- Sits between the link-training/config logic (requester) and the clock divider plus its serializer, encoder and FSM consumers.

---
 rtl/clk_speed_switch_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/clk_speed_switch_ctrl.sv
// ---------------------------------------------------------------------------
// clk_speed_switch_ctrl
//
// Sequences a generation-speed change (Gen4/Gen3/Gen2) on the local clock
// divider so downstream consumers never see a runt or glitched clock:
//   drain the link -> gate clock enables -> hold divider in reset while the
//   new speed is applied -> let the divided clocks settle -> release.
// Out of reset the block runs one settle/release pass at DEFAULT_SPEED
// without signalling done.
//
// Ports
//   local_clk  in   fast local clock, all logic on its rising edge
//   rst        in   asynchronous active-low reset
//   req_valid  in   speed-change request valid
//   req_speed  in   requested speed (00 Gen4, 01 Gen3, 10 Gen2, 11 illegal)
//   req_ready  out  request can be accepted this cycle
//   link_idle  in   datapath has no traffic in flight
//   gen_speed  out  speed select to the clock divider
//   div_rst_n  out  synchronous active-low divider reset
//   clk_en     out  enable for divided-clock consumers
//   busy       out  a switch sequence is in progress
//   done       out  one-cycle pulse, request completed
//   err        out  one-cycle pulse, illegal speed or drain timeout
// ---------------------------------------------------------------------------
module clk_speed_switch_ctrl #(
    parameter logic [1:0] DEFAULT_SPEED = 2'b00,
    parameter int         GATE_CYCLES   = 4,
    parameter int         RST_CYCLES    = 2,
    parameter int         SETTLE_CYCLES = 66,
    parameter int         DRAIN_TIMEOUT = 256,
    parameter int         CNT_W         = 9
) (
    input  logic       local_clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [1:0] req_speed,
    output logic       req_ready,
    input  logic       link_idle,
    output logic [1:0] gen_speed,
    output logic       div_rst_n,
    output logic       clk_en,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_DRAIN   = 3'd1;
    localparam logic [2:0] S_GATE    = 3'd2;
    localparam logic [2:0] S_DIV_RST = 3'd3;
    localparam logic [2:0] S_SETTLE  = 3'd4;
    localparam logic [2:0] S_RELEASE = 3'd5;

    localparam logic [CNT_W-1:0] GATE_LAST   = CNT_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_TIMEOUT - 1);

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_tgt;
    logic             r_init;      // set until the post-reset pass finishes
    logic [1:0]       r_gen_speed;
    logic             r_req_ready;
    logic             r_div_rst_n;
    logic             r_clk_en;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    logic [2:0] w_next_state;
    logic       w_accept;
    logic       w_illegal;
    logic       w_same;
    logic       w_start;
    logic       w_timeout;

    // req_ready is registered, so a handshake is only honoured while the
    // FSM is still sitting in IDLE.
    assign w_accept  = (r_state == S_IDLE) && req_valid && r_req_ready;
    assign w_illegal = w_accept && (req_speed == 2'b11);
    assign w_same    = w_accept && !w_illegal && (req_speed == r_gen_speed);
    assign w_start   = w_accept && !w_illegal && !w_same;
    // link_idle wins over the timeout when both land on the last drain cycle
    assign w_timeout = (r_state == S_DRAIN) && !link_idle && (r_cnt == DRAIN_LAST);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (w_start) w_next_state = S_DRAIN;
            S_DRAIN: begin
                if (link_idle)      w_next_state = S_GATE;
                else if (w_timeout) w_next_state = S_IDLE;
            end
            S_GATE:    if (r_cnt == GATE_LAST)   w_next_state = S_DIV_RST;
            S_DIV_RST: if (r_cnt == RST_LAST)    w_next_state = S_SETTLE;
            S_SETTLE:  if (r_cnt == SETTLE_LAST) w_next_state = S_RELEASE;
            S_RELEASE: w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge local_clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_SETTLE;
            r_cnt   <= '0;
            r_tgt   <= DEFAULT_SPEED;
            r_init  <= 1'b1;
        end else begin
            r_state <= w_next_state;
            if (w_next_state != r_state)
                r_cnt <= '0;
            else if (r_state != S_IDLE)
                r_cnt <= r_cnt + CNT_W'(1);
            if (w_start)
                r_tgt <= req_speed;
            if (r_state == S_RELEASE)
                r_init <= 1'b0;
        end
    end

    // Outputs follow the state one cycle later, so clk_en is already low a
    // full cycle before div_rst_n drops and the speed select moves.
    always_ff @(posedge local_clk or negedge rst) begin
        if (!rst) begin
            r_gen_speed <= DEFAULT_SPEED;
            r_req_ready <= 1'b0;
            r_div_rst_n <= 1'b1;
            r_clk_en    <= 1'b0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_clk_en    <= !((r_state == S_GATE) || (r_state == S_DIV_RST) ||
                             (r_state == S_SETTLE));
            r_div_rst_n <= (r_state != S_DIV_RST);
            if (r_state == S_DIV_RST)
                r_gen_speed <= r_tgt;
            r_busy      <= (w_next_state != S_IDLE);
            r_req_ready <= (r_state == S_IDLE) && (w_next_state == S_IDLE);
            r_done      <= ((r_state == S_RELEASE) && !r_init) || w_same;
            r_err       <= w_illegal || w_timeout;
        end
    end

    assign gen_speed = r_gen_speed;
    assign req_ready = r_req_ready;
    assign div_rst_n = r_div_rst_n;
    assign clk_en    = r_clk_en;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule
